// File: rtl/instr_decode_stage_if.sv
// Interface for the ID stage.
// It bundles three groups of signals:
//   - IF/ID inputs: II_Instruction and II_PC1_ADD_out.
//   - The branch-taken strobe PCSrc.
//   - The write-back port: WB_RegWrite, WB_WriteReg and WB_WriteData.
// It also carries the hazard controls (PC_Write, II_Write) and the ID/EX register outputs (DE_*).
// Modports:
//   - master: the upstream/downstream environment, which drives the stage inputs.
//   - slave:  the instr_decode_stage itself.
interface instr_decode_stage_if;
  logic [31:0] II_Instruction;
  logic [31:0] II_PC1_ADD_out;
  logic        PCSrc;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;

  logic        PC_Write;
  logic        II_Write;

  logic        DE_RegWrite;
  logic        DE_MemtoReg;
  logic        DE_MemRead;
  logic        DE_MemWrite;
  logic        DE_Branch;
  logic        DE_ALUSrc;
  logic        DE_RegDst;
  logic [2:0]  DE_ALUCtrl;
  logic [31:0] DE_PC1_ADD_out;
  logic [31:0] DE_ReadData1;
  logic [31:0] DE_ReadData2;
  logic [31:0] DE_SignExt;
  logic [4:0]  DE_Rs;
  logic [4:0]  DE_Rt;
  logic [4:0]  DE_Rd;

  modport master (
    output II_Instruction, II_PC1_ADD_out, PCSrc, WB_RegWrite, WB_WriteReg, WB_WriteData,
    input  PC_Write, II_Write,
    input  DE_RegWrite, DE_MemtoReg, DE_MemRead, DE_MemWrite, DE_Branch, DE_ALUSrc, DE_RegDst,
    input  DE_ALUCtrl, DE_PC1_ADD_out, DE_ReadData1, DE_ReadData2, DE_SignExt,
    input  DE_Rs, DE_Rt, DE_Rd
  );

  modport slave (
    input  II_Instruction, II_PC1_ADD_out, PCSrc, WB_RegWrite, WB_WriteReg, WB_WriteData,
    output PC_Write, II_Write,
    output DE_RegWrite, DE_MemtoReg, DE_MemRead, DE_MemWrite, DE_Branch, DE_ALUSrc, DE_RegDst,
    output DE_ALUCtrl, DE_PC1_ADD_out, DE_ReadData1, DE_ReadData2, DE_SignExt,
    output DE_Rs, DE_Rt, DE_Rd
  );
endinterface

// File: rtl/instr_decode_stage.sv
// MIPS ID stage.
// What it does:
//   - Decodes the IF/ID instruction.
//   - Reads the 32x32 register file, with write-back bypass.
//   - Detects load-use hazards and returns PC_Write/II_Write to IF.
//   - Squashes wrong-path instructions around a taken branch.
//   - Registers the result into the ID/EX register.
// Ports:
//   clk - clock; all state updates on posedge.
//   rst - asynchronous, active-high reset.
//   id  - instr_decode_stage_if.slave. It carries:
//           - IF/ID inputs and PCSrc;
//           - the WB write port;
//           - PC_Write/II_Write;
//           - all DE_* outputs.
module instr_decode_stage #(
  parameter logic [31:0] S0_INIT = 32'h0000_0000,
  parameter logic [31:0] S1_INIT = 32'h0000_0040,
  parameter logic [31:0] S4_INIT = 32'h0000_0040
) (
  input logic                 clk,
  input logic                 rst,
  instr_decode_stage_if.slave id
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBne   = 6'b000101;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign opcode = id.II_Instruction[31:26];
  assign rs     = id.II_Instruction[25:21];
  assign rt     = id.II_Instruction[20:16];
  assign rd     = id.II_Instruction[15:11];
  assign funct  = id.II_Instruction[5:0];
  assign imm    = id.II_Instruction[15:0];

  // Decoded controls
  logic       reg_write, memto_reg, mem_read, mem_write, branch, alu_src, reg_dst;
  logic [2:0] alu_ctrl;

  always_comb begin
    reg_write = 1'b0;
    memto_reg = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    alu_ctrl  = 3'b000;
    case (opcode)
      OpRtype: begin
        // Unknown funct values, including 000000 (NOP), leave every control at 0.
        case (funct)
          FnAdd:   begin reg_write = 1'b1; reg_dst = 1'b1; alu_ctrl = AluAdd; end
          FnSub:   begin reg_write = 1'b1; reg_dst = 1'b1; alu_ctrl = AluSub; end
          FnAnd:   begin reg_write = 1'b1; reg_dst = 1'b1; alu_ctrl = AluAnd; end
          FnOr:    begin reg_write = 1'b1; reg_dst = 1'b1; alu_ctrl = AluOr;  end
          FnSlt:   begin reg_write = 1'b1; reg_dst = 1'b1; alu_ctrl = AluSlt; end
          default: ;
        endcase
      end
      OpLw: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
        memto_reg = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = AluAdd;
      end
      OpSw: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = AluAdd;
      end
      OpAddi: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = AluAdd;
      end
      OpBne: begin
        branch   = 1'b1;
        alu_ctrl = AluSub;
      end
      default: ;
    endcase
  end

  // Register file
  logic [31:0] rf_q [32];
  logic        wb_en;

  assign wb_en = id.WB_RegWrite && (id.WB_WriteReg != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0;
      end
      rf_q[16] <= S0_INIT;
      rf_q[17] <= S1_INIT;
      rf_q[20] <= S4_INIT;
    end else if (wb_en) begin
      rf_q[id.WB_WriteReg] <= id.WB_WriteData;
    end
  end

  // Write-through: the value being written back this cycle is visible to the reader now.
  logic [31:0] read_data1, read_data2;

  always_comb begin
    read_data1 = rf_q[rs];
    if (rs == 5'd0) begin
      read_data1 = 32'h0;
    end else if (wb_en && (id.WB_WriteReg == rs)) begin
      read_data1 = id.WB_WriteData;
    end
  end

  always_comb begin
    read_data2 = rf_q[rt];
    if (rt == 5'd0) begin
      read_data2 = 32'h0;
    end else if (wb_en && (id.WB_WriteReg == rt)) begin
      read_data2 = id.WB_WriteData;
    end
  end

  // Hazard and squash
  logic flush_pend_q;
  logic uses_rt, is_nop, load_use, stall, bubble;

  assign uses_rt  = (opcode == OpRtype) || (opcode == OpSw) || (opcode == OpBne);
  assign is_nop   = (opcode == OpRtype) && (funct == 6'b000000);
  assign load_use = id.DE_MemRead && (id.DE_Rt != 5'd0) && !is_nop &&
                    ((id.DE_Rt == rs) || (uses_rt && (id.DE_Rt == rt)));
  // While flush_pend_q is set, the ID instruction is being thrown away,
  // so it must never stall the front end.
  assign stall    = load_use && !flush_pend_q;
  assign bubble   = stall || id.PCSrc || flush_pend_q;

  // PCSrc wins over a stall so the branch target is always loaded.
  assign id.PC_Write = !stall || id.PCSrc;
  assign id.II_Write = !stall || id.PCSrc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= id.PCSrc;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id.DE_RegWrite    <= 1'b0;
      id.DE_MemtoReg    <= 1'b0;
      id.DE_MemRead     <= 1'b0;
      id.DE_MemWrite    <= 1'b0;
      id.DE_Branch      <= 1'b0;
      id.DE_ALUSrc      <= 1'b0;
      id.DE_RegDst      <= 1'b0;
      id.DE_ALUCtrl     <= 3'b000;
      id.DE_PC1_ADD_out <= 32'h0;
      id.DE_ReadData1   <= 32'h0;
      id.DE_ReadData2   <= 32'h0;
      id.DE_SignExt     <= 32'h0;
      id.DE_Rs          <= 5'd0;
      id.DE_Rt          <= 5'd0;
      id.DE_Rd          <= 5'd0;
    end else begin
      // A bubble clears only the controls; the data fields load as usual.
      id.DE_RegWrite    <= reg_write && !bubble;
      id.DE_MemtoReg    <= memto_reg && !bubble;
      id.DE_MemRead     <= mem_read && !bubble;
      id.DE_MemWrite    <= mem_write && !bubble;
      id.DE_Branch      <= branch && !bubble;
      id.DE_ALUSrc      <= alu_src && !bubble;
      id.DE_RegDst      <= reg_dst && !bubble;
      id.DE_ALUCtrl     <= bubble ? 3'b000 : alu_ctrl;
      id.DE_PC1_ADD_out <= id.II_PC1_ADD_out;
      id.DE_ReadData1   <= read_data1;
      id.DE_ReadData2   <= read_data2;
      id.DE_SignExt     <= {{16{imm[15]}}, imm};
      id.DE_Rs          <= rs;
      id.DE_Rt          <= rt;
      id.DE_Rd          <= rd;
    end
  end

endmodule
